// File: rtl/mx_e3m2_dequant_if.sv
// Stream bundle for the MXFP6 (E3M2) block decoder.
// Block-in and beat-out handshakes are carried together.
interface mx_e3m2_dequant_if #(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned LANES      = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [7:0]                in_scale;
  logic [6*BLOCK_SIZE-1:0]   in_elems;
  logic                      out_valid;
  logic                      out_ready;
  logic [32*LANES-1:0]       out_data;
  logic                      out_first;
  logic                      out_last;

  modport master (
    output in_valid, in_scale, in_elems, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_scale, in_elems, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/mx_e3m2_dequant.sv
// Streaming MXFP6 (E3M2) block to FP32 decoder: latches one block with its E8M0 scale and
// emits LANES FP32 results per beat; the next block is accepted on the last-beat handshake.
module mx_e3m2_dequant #(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned LANES      = 4
) (
  input logic            clk,
  input logic            rst_n,
  mx_e3m2_dequant_if.slave bus
);
  localparam int unsigned NBEATS = BLOCK_SIZE / LANES;
  localparam int unsigned BeatW  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                  state_q, state_d;
  logic [BeatW-1:0]        beat_q;
  logic [7:0]              scale_q;
  logic [6*BLOCK_SIZE-1:0] elems_q;
  logic                    last_beat;
  logic                    accept;

  assign last_beat = (beat_q == BeatW'(NBEATS - 1));
  assign accept    = bus.in_valid & bus.in_ready;

  function automatic logic [31:0] decode(input logic [7:0] x, input logic [5:0] c);
    logic              s;
    logic [2:0]        e;
    logic [1:0]        m;
    logic signed [9:0] xe;
    logic signed [9:0] eo;
    logic [22:0]       mo;
    s  = c[5];
    e  = c[4:2];
    m  = c[1:0];
    xe = signed'({2'b00, x});
    eo = xe + signed'({7'b0, e}) - 10'sd3;
    mo = {m, 21'b0};
    if (e == 3'd0) begin
      // E3M2 subnormals land on exact FP32 normals, so only exponent and top bit differ
      case (m)
        2'd1:    begin eo = xe - 10'sd4; mo = '0;            end
        2'd2:    begin eo = xe - 10'sd3; mo = '0;            end
        2'd3:    begin eo = xe - 10'sd3; mo = {1'b1, 22'b0}; end
        default: begin eo = '0;          mo = '0;            end
      endcase
    end
    if (x == 8'hFF)                     decode = 32'h7FC0_0000;
    else if (e == 3'd0 && m == 2'd0)    decode = {s, 31'b0};
    else if (eo <= 10'sd0)              decode = {s, 31'b0};
    else if (eo >= 10'sd255)            decode = {s, 8'hFF, 23'b0};
    else                                decode = {s, eo[7:0], mo};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StStream;
      StStream: if (bus.out_ready && last_beat) state_d = accept ? StStream : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake and framing outputs
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_first = 1'b0;
    bus.out_last  = 1'b0;
    unique case (state_q)
      StIdle:   bus.in_ready = 1'b1;
      StStream: begin
        bus.in_ready  = bus.out_ready & last_beat;
        bus.out_valid = 1'b1;
        bus.out_first = (beat_q == '0);
        bus.out_last  = last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      scale_q <= '0;
      elems_q <= '0;
    end else if (accept) begin
      beat_q  <= '0;
      scale_q <= bus.in_scale;
      elems_q <= bus.in_elems;
    end else if (state_q == StStream && bus.out_ready) begin
      beat_q  <= last_beat ? '0 : beat_q + BeatW'(1);
    end
  end

  // Block regs reset to zero, which decodes to +0 on every lane
  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      bus.out_data[32*j +: 32] = decode(scale_q, elems_q[6*(int'(beat_q)*int'(LANES) + j) +: 6]);
    end
  end
endmodule

// File: tb/tb_mx_e3m2_dequant.sv
// Scoreboard bench for mx_e3m2_dequant: stimulus pushes expected beats, a negedge monitor
// pops and compares on every output handshake.
module tb_mx_e3m2_dequant;
  localparam int unsigned BS = 32;
  localparam int unsigned LN = 4;
  localparam int unsigned NB = BS / LN;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mx_e3m2_dequant_if #(.BLOCK_SIZE(BS), .LANES(LN)) bus ();
  mx_e3m2_dequant #(.BLOCK_SIZE(BS), .LANES(LN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [32*LN-1:0] data;
    logic             first;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int hs_count = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int acc_cyc = 0;

  // Hand-decoded codes at scale 127
  logic [5:0]  tab_code[8] = '{6'h0C, 6'h23, 6'h01, 6'h20, 6'h11, 6'h02, 6'h1F, 6'h0A};
  logic [31:0] tab_val[8]  = '{32'h3F80_0000, 32'hBE40_0000, 32'h3D80_0000, 32'h8000_0000,
                               32'h4020_0000, 32'h3E00_0000, 32'h41E0_0000, 32'h3F40_0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [6*BS-1:0] uni_elems(input logic [5:0] code);
    logic [6*BS-1:0] r;
    for (int i = 0; i < int'(BS); i++) r[6*i +: 6] = code;
    return r;
  endfunction

  function automatic logic [32*BS-1:0] uni_exp(input logic [31:0] w);
    logic [32*BS-1:0] r;
    for (int i = 0; i < int'(BS); i++) r[32*i +: 32] = w;
    return r;
  endfunction

  // Element (beat b, lane j) uses table entry (b+j)%8, exposing lane/beat ordering errors
  function automatic logic [6*BS-1:0] tab_elems();
    logic [6*BS-1:0] r;
    for (int i = 0; i < int'(BS); i++) r[6*i +: 6] = tab_code[(i/int'(LN) + i%int'(LN)) % 8];
    return r;
  endfunction

  function automatic logic [32*BS-1:0] tab_exp();
    logic [32*BS-1:0] r;
    for (int i = 0; i < int'(BS); i++) r[32*i +: 32] = tab_val[(i/int'(LN) + i%int'(LN)) % 8];
    return r;
  endfunction

  task automatic send_block(input logic [7:0] x, input logic [6*BS-1:0] el,
                            input logic [32*BS-1:0] ex);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_scale = x;
    bus.in_elems = el;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    for (int b = 0; b < int'(NB); b++)
      exp_q.push_back('{data: ex[32*LN*b +: 32*LN], first: (b == 0), last: (b == int'(NB) - 1)});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output handshake against the scoreboard head
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      hs_count++;
      last_hs_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data %h expected no beat", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat", {30'b0, bus.out_data, bus.out_first, bus.out_last},
              {30'b0, e.data, e.first, e.last});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32*BS-1:0] ex;
    int base;
    int a0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_scale  = '0;
    bus.in_elems  = '0;
    bus.out_ready = 1'b1;
    #12;
    check("reset_out_valid", 160'(bus.out_valid), 160'(0));
    check("reset_first_last", 160'({bus.out_first, bus.out_last}), 160'(0));
    check("reset_out_data", 160'(bus.out_data), 160'(0));
    check("reset_in_ready", 160'(bus.in_ready), 160'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unit values, large normal, negative subnormal, mixed table
    send_block(8'd127, uni_elems(6'h0C), uni_exp(32'h3F80_0000));
    drain();
    send_block(8'd130, uni_elems(6'h1F), uni_exp(32'h4360_0000));
    send_block(8'd127, uni_elems(6'h23), uni_exp(32'hBE40_0000));
    send_block(8'd127, tab_elems(), tab_exp());
    drain();

    // Boundaries: NaN scale, overflow, flush, subnormal m=3
    send_block(8'hFF, tab_elems(), uni_exp(32'h7FC0_0000));
    send_block(8'd254, uni_elems(6'h1C), uni_exp(32'h7F80_0000));
    send_block(8'd2, uni_elems(6'h24), uni_exp(32'h8000_0000));
    send_block(8'd0, uni_elems(6'h0C), uni_exp(32'h0000_0000));
    send_block(8'd127, uni_elems(6'h03), uni_exp(32'h3E40_0000));
    drain();

    // Back-pressure at beat 2
    bus.out_ready = 1'b0;
    ex = tab_exp();
    send_block(8'd127, tab_elems(), ex);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", {30'b0, bus.out_data, bus.out_valid, bus.in_ready},
            {30'b0, ex[32*LN*2 +: 32*LN], 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // Two blocks back-to-back with no bubble
    base = hs_count;
    send_block(8'd127, uni_elems(6'h0C), uni_exp(32'h3F80_0000));
    a0 = acc_cyc;
    send_block(8'd127, tab_elems(), tab_exp());
    drain();
    check("b2b_beats", 160'(hs_count - base), 160'(2 * NB));
    check("b2b_span", 160'(last_hs_cyc - a0), 160'(2 * NB));

    // Reset during beat 3
    send_block(8'd127, tab_elems(), tab_exp());
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 160'(bus.out_valid), 160'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postreset_in_ready", 160'(bus.in_ready), 160'(1));
    send_block(8'd130, uni_elems(6'h1F), uni_exp(32'h4360_0000));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
